// File: rtl/dcm_spi_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dcm_spi_master
//
// SPI initiator for the DC-motor controller register port. A host command
// becomes one SPI frame: a command byte {write, addr[6:0]} followed by cmd_len
// data bytes. The slave auto-increments the register address for each data
// byte. SPI mode 0 (SCK idles low, data sampled on the rising edge), MSB first.
//
// Handshakes (strict valid/ready): a transfer happens on a clock edge where
// both valid and ready are high. Neither side may depend on the other side's
// valid/ready combinationally in a way that forms a loop. cmd_ready and
// wr_ready never depend on cmd_valid / wr_valid. rd_valid is a one-cycle
// pulse with no backpressure.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   cmd_valid/ready   command handshake; ready is high only while idle
//   cmd_write         1 = write frame, 0 = read frame
//   cmd_addr, cmd_len start register address, number of data bytes (0..127)
//   wr_data/valid/rdy write byte stream for write frames
//   rd_data, rd_valid received byte and its one-cycle strobe (read frames)
//   busy              high from command accept until done
//   done              one-cycle pulse after the inter-frame gap
//   spi_ss/clk/mosi   SPI outputs (ss active low, clk idles low)
//   spi_miso          SPI input
//   fsm_state         current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module dcm_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [6:0] cmd_addr,
  input  logic [6:0] cmd_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       spi_ss,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  // One shared cycle counter serves every timed phase, so it is sized for
  // the largest of the timing parameters.
  localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       byte_q;   // index of the byte on the wire (0 = command)
  logic             write_q;
  logic [6:0]       addr_q;
  logic [6:0]       len_q;
  logic [6:0]       tx_q;     // remaining bits to send; MSB already on mosi
  logic [6:0]       rx_q;     // bits received so far in this byte

  // Next values of the registered outputs.
  logic       ss_n, sck_n, mosi_n, cmd_ready_n, busy_n, done_n, rd_valid_n;
  logic [7:0] rd_data_n;

  // Shared condition terms.
  logic       accept;
  logic       is_data;
  logic       load_stall;
  logic [7:0] load_byte;
  logic       setup_last, div_last, hold_last, gap_last;
  logic       sample;
  logic       byte_end;
  logic       last_byte;

  assign accept     = (state_q == S_IDLE) && cmd_valid && cmd_ready;
  assign is_data    = (byte_q != 8'd0);
  assign load_stall = (state_q == S_LOAD) && is_data && write_q && !wr_valid;
  assign load_byte  = !is_data ? {write_q, addr_q} :
                      (write_q ? wr_data : 8'h00);

  assign setup_last = (cnt_q == CNT_W'(CS_SETUP - 1));
  assign div_last   = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign hold_last  = (cnt_q == CNT_W'(CS_HOLD - 1));
  assign gap_last   = (cnt_q == CNT_W'(CS_GAP - 1));

  // miso is captured in the last clk cycle of each SCK high phase, which is
  // also the cycle that produces the falling edge.
  assign sample    = (state_q == S_SHIFT) && spi_clk && div_last;
  assign byte_end  = sample && (bit_q == 3'd7);
  assign last_byte = (byte_q == {1'b0, len_q});

  assign wr_ready  = (state_q == S_LOAD) && is_data && write_q;
  assign fsm_state = state_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)      state_d = S_SETUP;
      S_SETUP: if (setup_last)  state_d = S_LOAD;
      S_LOAD:  if (!load_stall) state_d = S_SHIFT;
      S_SHIFT: if (byte_end)    state_d = last_byte ? S_HOLD : S_LOAD;
      S_HOLD:  if (hold_last)   state_d = S_GAP;
      S_GAP:   if (gap_last)    state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    ss_n        = spi_ss;
    sck_n       = spi_clk;
    mosi_n      = spi_mosi;
    cmd_ready_n = cmd_ready;
    busy_n      = busy;
    done_n      = 1'b0;
    rd_valid_n  = 1'b0;
    rd_data_n   = rd_data;
    case (state_q)
      S_IDLE: begin
        cmd_ready_n = 1'b1;
        if (accept) begin
          cmd_ready_n = 1'b0;
          busy_n      = 1'b1;
          ss_n        = 1'b0;
        end
      end
      S_SETUP: sck_n = 1'b0;
      S_LOAD: begin
        sck_n = 1'b0;
        if (!load_stall) mosi_n = load_byte[7];
      end
      S_SHIFT: begin
        if (div_last) begin
          if (!spi_clk) begin
            sck_n = 1'b1;
          end else begin
            sck_n = 1'b0;
            // Next bit goes out with the falling edge; the first bit of the
            // following byte is driven from LOAD instead.
            if (bit_q != 3'd7) mosi_n = tx_q[6];
            if (byte_end && is_data && !write_q) begin
              rd_data_n  = {rx_q, spi_miso};
              rd_valid_n = 1'b1;
            end
          end
        end
      end
      S_HOLD: begin
        if (hold_last) begin
          ss_n   = 1'b1;
          mosi_n = 1'b0;
        end
      end
      S_GAP: begin
        if (gap_last) begin
          done_n      = 1'b1;
          busy_n      = 1'b0;
          cmd_ready_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spi_ss    <= 1'b1;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 8'h00;
    end else begin
      spi_ss    <= ss_n;
      spi_clk   <= sck_n;
      spi_mosi  <= mosi_n;
      cmd_ready <= cmd_ready_n;
      busy      <= busy_n;
      done      <= done_n;
      rd_valid  <= rd_valid_n;
      rd_data   <= rd_data_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: counters, command latch, shift registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 8'd0;
      write_q <= 1'b0;
      addr_q  <= 7'd0;
      len_q   <= 7'd0;
      tx_q    <= 7'd0;
      rx_q    <= 7'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (accept) begin
            write_q <= cmd_write;
            addr_q  <= cmd_addr;
            len_q   <= cmd_len;
            byte_q  <= 8'd0;
          end
        end
        S_SETUP: cnt_q <= setup_last ? '0 : cnt_q + CNT_W'(1);
        S_LOAD: begin
          cnt_q <= '0;
          bit_q <= 3'd0;
          if (!load_stall) tx_q <= load_byte[6:0];
        end
        S_SHIFT: begin
          cnt_q <= div_last ? '0 : cnt_q + CNT_W'(1);
          if (sample) begin
            rx_q <= {rx_q[5:0], spi_miso};
            if (bit_q == 3'd7) begin
              byte_q <= byte_q + 8'd1;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= {tx_q[5:0], 1'b0};
            end
          end
        end
        S_HOLD: cnt_q <= hold_last ? '0 : cnt_q + CNT_W'(1);
        S_GAP:  cnt_q <= gap_last ? '0 : cnt_q + CNT_W'(1);
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule
